// File: rtl/piped_adder_pkg.sv
// Shared sizing helpers for piped_adder: stage count, per-stage slice width and latency.
// Latency includes the clamp stage when PIPED_ADDER_SAT_EN is defined.
package piped_adder_pkg;

    typedef enum logic [1:0] {
        RST_ASYNEG = 2'd0,
        RST_ASYPOS = 2'd1,
        RST_SYNNEG = 2'd2,
        RST_SYNPOS = 2'd3
    } reset_kind_e;

    function automatic int num_stages(input int width, input int chunk);
        return (width + chunk) / chunk;   // ceil((width+1)/chunk)
    endfunction

    function automatic int chunk_width(input int width, input int chunk, input int k);
        int remaining;
        remaining = width + 1 - k * chunk;
        return (remaining < chunk) ? remaining : chunk;
    endfunction

    function automatic int latency(input int width, input int chunk);
`ifdef PIPED_ADDER_SAT_EN
        return num_stages(width, chunk) + 1;
`else
        return num_stages(width, chunk);
`endif
    endfunction

endpackage

// File: rtl/conv_reg.sv
// Generic delay line of LENGTH registers (LENGTH=0 is a plain wire) with a
// selectable reset flavour: "ASYNEG", "ASYPOS", "SYNNEG" or "SYNPOS".
module conv_reg #(
    parameter int    WIDTH      = 1,
    parameter int    LENGTH     = 1,
    parameter string RESET_TYPE = "ASYNEG"
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (LENGTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = clk ^ reset;
            assign dout = din;
        end else begin : g_line
            for (genvar gi = 0; gi < LENGTH; gi++) begin : g_tap
                logic [WIDTH-1:0] tap_reg;
                logic [WIDTH-1:0] tap_next;

                if (gi == 0) begin : g_head
                    assign tap_next = din;
                end else begin : g_body
                    assign tap_next = g_tap[gi-1].tap_reg;
                end

                if (RESET_TYPE == "ASYNEG") begin : g_asyneg
                    always_ff @(posedge clk or negedge reset) begin
                        if (!reset) tap_reg <= '0;
                        else        tap_reg <= tap_next;
                    end
                end else if (RESET_TYPE == "ASYPOS") begin : g_asypos
                    always_ff @(posedge clk or posedge reset) begin
                        if (reset) tap_reg <= '0;
                        else       tap_reg <= tap_next;
                    end
                end else if (RESET_TYPE == "SYNNEG") begin : g_synneg
                    always_ff @(posedge clk) begin
                        if (!reset) tap_reg <= '0;
                        else        tap_reg <= tap_next;
                    end
                end else begin : g_synpos
                    always_ff @(posedge clk) begin
                        if (reset) tap_reg <= '0;
                        else       tap_reg <= tap_next;
                    end
                end
            end
            assign dout = g_tap[LENGTH-1].tap_reg;
        end
    endgenerate

endmodule

// File: rtl/piped_adder_stage.sv
// One slice of the pipelined adder: SW-bit add with carry-in, registered sum and carry-out.
module piped_adder_stage #(
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout
);

    logic [SW:0]   total_next;
    logic [SW-1:0] sum_reg;
    logic          cout_reg;

    assign total_next = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else begin
            sum_reg  <= total_next[SW-1:0];
            cout_reg <= total_next[SW];
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: rtl/piped_adder.sv
// Pipelined WIDTH-bit add/subtract producing an exact WIDTH+1-bit result, CHUNK bits per stage.
// Define PIPED_ADDER_SAT_EN to add a registered clamp to the WIDTH-bit range (latency N+1).
module piped_adder
    import piped_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CHUNK  = 4,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH:0]   out
);

    localparam int W1 = WIDTH + 1;
    localparam int N  = num_stages(WIDTH, CHUNK);

    logic [W1-1:0] a_ext;
    logic [W1-1:0] b_ext;
    logic [W1-1:0] b_op;
    logic [N-1:0]  carry;
    logic [W1-1:0] sum_raw;
    logic          valid_raw;
    logic          unused_carry;

    generate
        if (SIGNED != 0) begin : g_sext
            assign a_ext = {a[WIDTH-1], a};
            assign b_ext = {b[WIDTH-1], b};
        end else begin : g_zext
            assign a_ext = {1'b0, a};
            assign b_ext = {1'b0, b};
        end
    endgenerate

    // Subtraction as a + ~b + 1; the +1 enters as stage 0 carry-in.
    assign b_op = sub ? ~b_ext : b_ext;

    // The extended width already holds the exact result, so the top carry is dropped.
    assign unused_carry = carry[N-1];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_stage
            localparam int LSB = gi * CHUNK;
            localparam int SW  = chunk_width(WIDTH, CHUNK, gi);

            logic [SW-1:0] a_skew;
            logic [SW-1:0] b_skew;
            logic [SW-1:0] sum_slice;
            logic          cin;

            conv_reg #(
                .WIDTH      (2 * SW),
                .LENGTH     (gi),
                .RESET_TYPE ("ASYNEG")
            ) u_skew (
                .clk   (clk),
                .reset (reset_n),
                .din   ({a_ext[LSB +: SW], b_op[LSB +: SW]}),
                .dout  ({a_skew, b_skew})
            );

            if (gi == 0) begin : g_cin_sub
                assign cin = sub;
            end else begin : g_cin_chain
                assign cin = carry[gi-1];
            end

            piped_adder_stage #(
                .SW (SW)
            ) u_stage (
                .clk     (clk),
                .reset_n (reset_n),
                .a       (a_skew),
                .b       (b_skew),
                .cin     (cin),
                .sum     (sum_slice),
                .cout    (carry[gi])
            );

            conv_reg #(
                .WIDTH      (SW),
                .LENGTH     (N - 1 - gi),
                .RESET_TYPE ("ASYNEG")
            ) u_deskew (
                .clk   (clk),
                .reset (reset_n),
                .din   (sum_slice),
                .dout  (sum_raw[LSB +: SW])
            );
        end
    endgenerate

    conv_reg #(
        .WIDTH      (1),
        .LENGTH     (N),
        .RESET_TYPE ("ASYNEG")
    ) u_valid_pipe (
        .clk   (clk),
        .reset (reset_n),
        .din   (in_valid),
        .dout  (valid_raw)
    );

`ifdef PIPED_ADDER_SAT_EN
    localparam logic [W1-1:0] SMAX = (W1'(1) << (WIDTH - 1)) - W1'(1);
    localparam logic [W1-1:0] UMAX = (W1'(1) << WIDTH) - W1'(1);

    logic          sub_late;
    logic [W1-1:0] sat_next;
    logic [W1-1:0] out_reg;
    logic          valid_reg;

    // Unsigned results are ambiguous in the top bit; the op's sub tells underflow from overflow.
    conv_reg #(
        .WIDTH      (1),
        .LENGTH     (N),
        .RESET_TYPE ("ASYNEG")
    ) u_sub_pipe (
        .clk   (clk),
        .reset (reset_n),
        .din   (sub),
        .dout  (sub_late)
    );

    always_comb begin
        sat_next = sum_raw;
        if (SIGNED != 0) begin
            if (!sum_raw[W1-1] && sum_raw[W1-2])
                sat_next = SMAX;
            else if (sum_raw[W1-1] && !sum_raw[W1-2])
                sat_next = ~SMAX;
        end else if (sum_raw[W1-1]) begin
            sat_next = sub_late ? '0 : UMAX;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            out_reg   <= sat_next;
            valid_reg <= valid_raw;
        end
    end

    assign out       = out_reg;
    assign out_valid = valid_reg;
`else
    assign out       = sum_raw;
    assign out_valid = valid_raw;
`endif

endmodule

// File: tb/tb_piped_adder.sv
// Directed bench for piped_adder: a signed and an unsigned instance share stimulus;
// expected results are hand-computed and scheduled L cycles after each sampled input.
module tb_piped_adder;
    import piped_adder_pkg::*;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int L     = latency(WIDTH, CHUNK);
    localparam int DEPTH = 256;

`ifdef PIPED_ADDER_SAT_EN
    localparam logic [16:0] V1_S = 17'h07FFF, V1_U = 17'h08000;
    localparam logic [16:0] V2_S = 17'h18000, V2_U = 17'h07FFF;
    localparam logic [16:0] V3_S = 17'h00000, V3_U = 17'h0FFFF;
    localparam logic [16:0] V4_S = 17'h00001, V4_U = 17'h00000;
    localparam logic [16:0] B2_S = 17'h1FFFC, B2_U = 17'h00000;
    localparam logic [16:0] B3_S = 17'h18000, B3_U = 17'h0FFFF;
    localparam logic [16:0] B4_S = 17'h1F1FE, B4_U = 17'h00000;
`else
    localparam logic [16:0] V1_S = 17'h08000, V1_U = 17'h08000;
    localparam logic [16:0] V2_S = 17'h17FFF, V2_U = 17'h07FFF;
    localparam logic [16:0] V3_S = 17'h00000, V3_U = 17'h10000;
    localparam logic [16:0] V4_S = 17'h00001, V4_U = 17'h10001;
    localparam logic [16:0] B2_S = 17'h1FFFC, B2_U = 17'h1FFFC;
    localparam logic [16:0] B3_S = 17'h18000, B3_U = 17'h18000;
    localparam logic [16:0] B4_S = 17'h1F1FE, B4_U = 17'h1F1FE;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid_s, out_valid_u;
    logic [16:0] out_s, out_u;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic        exp_v [DEPTH];
    logic [16:0] exp_s [DEPTH];
    logic [16:0] exp_u [DEPTH];

    always #5 clk = ~clk;

    piped_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK), .SIGNED(1)) dut_s (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid_s),
        .out       (out_s)
    );

    piped_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK), .SIGNED(0)) dut_u (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid_u),
        .out       (out_u)
    );

    task automatic check(input string tag, input logic [16:0] observed, input logic [16:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clear_expect();
        for (int i = 0; i < DEPTH; i++) begin
            exp_v[i] = 1'b0;
            exp_s[i] = '0;
            exp_u[i] = '0;
        end
    endtask

    // One clock step: check outputs due now, then drive the next operation.
    task automatic tick(input logic v, input logic s, input logic [15:0] aa, input logic [15:0] bb,
                        input logic [16:0] es, input logic [16:0] eu);
        @(negedge clk);
        check($sformatf("valid_s@%0d", cyc), {16'b0, out_valid_s}, {16'b0, exp_v[cyc]});
        check($sformatf("valid_u@%0d", cyc), {16'b0, out_valid_u}, {16'b0, exp_v[cyc]});
        if (exp_v[cyc]) begin
            check($sformatf("out_s@%0d", cyc), out_s, exp_s[cyc]);
            check($sformatf("out_u@%0d", cyc), out_u, exp_u[cyc]);
        end
        in_valid = v;
        sub      = s;
        a        = aa;
        b        = bb;
        if (v) begin
            exp_v[cyc + L] = 1'b1;
            exp_s[cyc + L] = es;
            exp_u[cyc + L] = eu;
        end
        $display("cyc %0d: in_valid=%0b sub=%0b a=%h b=%h | out_valid_s=%0b out_s=%h out_valid_u=%0b out_u=%h",
                 cyc, v, s, aa, bb, out_valid_s, out_s, out_valid_u, out_u);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0000, 16'h0000, 17'h0, 17'h0);
    endtask

    initial begin
        clear_expect();

        #1;
        check("reset_out_s", out_s, 17'h0);
        check("reset_valid_s", {16'b0, out_valid_s}, 17'h0);
        check("reset_out_u", out_u, 17'h0);
        check("reset_valid_u", {16'b0, out_valid_u}, 17'h0);
        #11 reset_n = 1'b1;

        // Single add, subtract underflow, full carry ripple, extension-sensitive subtract
        tick(1'b1, 1'b0, 16'h7FFF, 16'h0001, V1_S, V1_U);
        idle(L + 1);
        tick(1'b1, 1'b1, 16'h8000, 16'h0001, V2_S, V2_U);
        idle(L + 1);
        tick(1'b1, 1'b0, 16'hFFFF, 16'h0001, V3_S, V3_U);
        idle(L + 1);
        tick(1'b1, 1'b1, 16'h0000, 16'hFFFF, V4_S, V4_U);
        idle(L + 1);

        // Streaming: 8 back-to-back ops with alternating sub
        for (int i = 0; i < 8; i++) begin
            logic [15:0] iv;
            logic [16:0] ev;
            iv = 16'(i);
            ev = iv[0] ? 17'h0 : 17'(2 * i);
            tick(1'b1, iv[0], iv, iv, ev, ev);
        end
        idle(L + 1);

        // Bubbles: 1,0,1,1,0,1
        tick(1'b1, 1'b0, 16'h1234, 16'h0F0F, 17'h02143, 17'h02143);
        idle(1);
        tick(1'b1, 1'b1, 16'h0005, 16'h0009, B2_S, B2_U);
        tick(1'b1, 1'b0, 16'hC000, 16'hC000, B3_S, B3_U);
        idle(1);
        tick(1'b1, 1'b1, 16'h00FF, 16'h0F01, B4_S, B4_U);
        idle(L + 1);

        // Reset mid-stream while the first of three results is on the output
        tick(1'b1, 1'b0, 16'h0001, 16'h0002, 17'h00003, 17'h00003);
        tick(1'b1, 1'b1, 16'h000A, 16'h0003, 17'h00007, 17'h00007);
        tick(1'b1, 1'b0, 16'h0004, 16'h0004, 17'h00008, 17'h00008);
        idle(L - 3);
        tick(1'b0, 1'b0, 16'h0000, 16'h0000, 17'h0, 17'h0);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_out_s", out_s, 17'h0);
        check("midrst_valid_s", {16'b0, out_valid_s}, 17'h0);
        check("midrst_out_u", out_u, 17'h0);
        check("midrst_valid_u", {16'b0, out_valid_u}, 17'h0);
        #9 reset_n = 1'b1;
        clear_expect();
        idle(L + 1);
        tick(1'b1, 1'b0, 16'h0100, 16'h0023, 17'h00123, 17'h00123);
        idle(L + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
